// File: rtl/btn_conditioner.sv
// Button front-end: two-flop synchroniser, per-bit debounce, press/release pulses,
// one-hot direction decode and an auto-repeat move strobe.
module btn_conditioner #(
    parameter int NUM_BTN         = 5,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 40_000_000,
    parameter int REPEAT_PERIOD   = 8_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [3:0]         move_dir,
    output logic               move_strobe
);

    localparam int MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_P = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
    localparam int CW    = $clog2(MAX_P) + 1;

    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    logic [NUM_BTN-1:0] s1_q, s2_q;
    logic [NUM_BTN-1:0] stable_q, stable_d;
    logic [NUM_BTN-1:0] press_q, press_d;
    logic [NUM_BTN-1:0] release_q, release_d;
    logic [CW-1:0]      cnt_q [NUM_BTN];
    logic [CW-1:0]      cnt_d [NUM_BTN];
    state_t             state_q, state_d;
    logic [CW-1:0]      rcnt_q, rcnt_d;
    logic               strobe_q, strobe_d;
    logic [3:0]         dir_now, dir_next;

    function automatic logic [3:0] onehot_or_zero(input logic [3:0] x);
        if ((x != 4'd0) && ((x & (x - 4'd1)) == 4'd0)) return x;
        return 4'd0;
    endfunction

    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < NUM_BTN; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == DEB_LAST) begin
                    stable_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
        press_d   = stable_d & ~stable_q;
        release_d = ~stable_d & stable_q;
    end

    // The repeat FSM looks at the direction btn_level will show next cycle, so the
    // registered strobe lines up with the level change that caused it.
    assign dir_now  = onehot_or_zero(stable_q[4:1]);
    assign dir_next = onehot_or_zero(stable_d[4:1]);

    always_comb begin
        state_d  = state_q;
        rcnt_d   = rcnt_q;
        strobe_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (dir_next != 4'd0) begin
                    strobe_d = 1'b1;
                    rcnt_d   = '0;
                    state_d  = DELAY;
                end
            end
            DELAY, REPEAT: begin
                if (dir_next == 4'd0) begin
                    rcnt_d  = '0;
                    state_d = IDLE;
                end else if (dir_next != dir_now) begin
                    strobe_d = 1'b1;
                    rcnt_d   = '0;
                    state_d  = DELAY;
                end else if (rcnt_q == ((state_q == DELAY) ? DLY_LAST : PER_LAST)) begin
                    strobe_d = 1'b1;
                    rcnt_d   = '0;
                    state_d  = REPEAT;
                end else begin
                    rcnt_d = rcnt_q + CW'(1);
                end
            end
            default: begin
                rcnt_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q      <= '0;
            s2_q      <= '0;
            stable_q  <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= '0;
            state_q   <= IDLE;
            rcnt_q    <= '0;
            strobe_q  <= 1'b0;
        end else begin
            s1_q      <= btn_raw;
            s2_q      <= s1_q;
            stable_q  <= stable_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= cnt_d[i];
            state_q   <= state_d;
            rcnt_q    <= rcnt_d;
            strobe_q  <= strobe_d;
        end
    end

    assign btn_level   = stable_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign move_dir    = dir_now;
    assign move_strobe = strobe_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed literal checks plus random stimulus compared
// every cycle against a behavioural model of debounce and auto-repeat.
module tb_btn_conditioner;

    localparam int NB  = 5;
    localparam int DEB = 4;
    localparam int DLY = 10;
    localparam int PER = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level, btn_press, btn_release;
    logic [3:0]    move_dir;
    logic          move_strobe;

    int n_checks = 0;
    int n_errors = 0;
    bit started  = 1'b0;

    btn_conditioner #(
        .NUM_BTN(NB), .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)
    ) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
        .move_dir(move_dir), .move_strobe(move_strobe)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors < 40)
                $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: raw delayed two samples, a bit is accepted once it has
    // disagreed with the accepted value for DEB consecutive cycles; strobes fire on a
    // new single direction, then after DLY cycles, then every PER cycles.
    logic [NB-1:0] m_s1, m_s2, m_stable, m_press, m_release;
    logic [3:0]    m_dir, m_prev_dir;
    logic          m_strobe;
    int            m_diff [NB];
    int            m_since;
    bit            m_first;

    function automatic logic [3:0] single_dir(input logic [3:0] x);
        int n = 0;
        for (int i = 0; i < 4; i++) if (x[i]) n++;
        return (n == 1) ? x : 4'd0;
    endfunction

    task automatic model_step();
        logic [NB-1:0] old;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0; m_press = '0; m_release = '0;
            m_dir = '0; m_prev_dir = '0; m_strobe = 1'b0; m_since = 0; m_first = 1'b1;
            for (int b = 0; b < NB; b++) m_diff[b] = 0;
            return;
        end
        old = m_stable;
        for (int b = 0; b < NB; b++) begin
            if (m_s2[b] == m_stable[b]) m_diff[b] = 0;
            else begin
                m_diff[b]++;
                if (m_diff[b] == DEB) begin
                    m_stable[b] = m_s2[b];
                    m_diff[b]   = 0;
                end
            end
        end
        m_s2 = m_s1;
        m_s1 = btn_raw;
        m_press   = m_stable & ~old;
        m_release = ~m_stable & old;
        m_dir     = single_dir(m_stable[4:1]);
        m_strobe  = 1'b0;
        if (m_dir != 4'd0) begin
            if (m_dir != m_prev_dir) begin
                m_strobe = 1'b1; m_since = 0; m_first = 1'b1;
            end else begin
                m_since++;
                if (m_since == (m_first ? DLY : PER)) begin
                    m_strobe = 1'b1; m_since = 0; m_first = 1'b0;
                end
            end
        end
        m_prev_dir = m_dir;
    endtask

    always @(posedge clk) begin
        #1;
        model_step();
        if (started) begin
            check("level",   32'(btn_level),   32'(m_stable));
            check("press",   32'(btn_press),   32'(m_press));
            check("release", 32'(btn_release), 32'(m_release));
            check("dir",     32'(move_dir),    32'(m_dir));
            check("strobe",  32'(move_strobe), 32'(m_strobe));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [NB-1:0] r);
        @(negedge clk);
        btn_raw = r;
    endtask

    task automatic check_all_zero(input string name);
        check(name, {btn_level, btn_press, btn_release, move_dir, move_strobe}, 32'd0);
    endtask

    int cnt_a, cnt_b;

    initial begin
        rst = 1'b1;
        btn_raw = '0;
        repeat (3) tick();
        started = 1'b1;
        check_all_zero("reset_state");

        // Up held from cycle 0: level/press/strobe at edge 6, repeats at 16 and 19.
        @(negedge clk);
        rst = 1'b0;
        btn_raw = 5'b00010;
        for (int k = 1; k <= 19; k++) begin
            tick();
            check("t1_level1", 32'(btn_level[1]), 32'(k >= 6));
            check("t1_strobe", 32'(move_strobe), 32'(k == 6 || k == 16 || k == 19));
            if (k == 6) begin
                check("t1_press", 32'(btn_press), 32'h02);
                check("t1_dir", 32'(move_dir), 32'h1);
            end
            if (k == 7) check("t1_press_width", 32'(btn_press), 32'h0);
        end

        // Reset mid-repeat with up still held.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("t5_during_rst");
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("t5_strobe", 32'(move_strobe), 32'(k == 6));
            check("t5_press", 32'(btn_press[1]), 32'(k == 6));
        end

        // Right added: directions conflict; releasing up gives a fresh right strobe.
        drive(5'b01010);
        cnt_a = 0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (k >= 6) begin
                check("t4_dir_zero", 32'(move_dir), 32'h0);
                cnt_a += int'(move_strobe);
            end
        end
        check("t4_no_strobe", 32'(cnt_a), 32'd0);
        drive(5'b01000);
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("t4_fresh_strobe", 32'(move_strobe), 32'(k == 6));
        end
        check("t4_dir_right", 32'(move_dir), 32'h4);

        drive(5'b00000);
        repeat (10) tick();

        // Bounce on right every 2 cycles: never accepted.
        cnt_a = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            btn_raw = (((k / 2) % 2) == 0) ? 5'b01000 : 5'b00000;
            tick();
            cnt_a += int'(btn_level[3]) + int'(btn_press[3]) + int'(move_strobe);
        end
        check("t2_bounce_ignored", 32'(cnt_a), 32'd0);

        drive(5'b00000);
        repeat (10) tick();

        // Centre: press pulse, no direction, no strobe.
        drive(5'b00001);
        cnt_a = 0;
        cnt_b = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            cnt_a += int'(btn_press[0]);
            cnt_b += int'(move_strobe) + int'(move_dir != 4'd0);
        end
        check("t6_centre_press", 32'(cnt_a), 32'd1);
        check("t6_centre_no_move", 32'(cnt_b), 32'd0);
        drive(5'b00000);
        repeat (10) tick();

        // Random segments, checked by the per-cycle model.
        for (int seg = 0; seg < 300; seg++) begin
            logic [NB-1:0] pat;
            int len;
            case ($urandom_range(0, 5))
                0:       pat = '0;
                1, 2, 3: pat = NB'(1) << $urandom_range(0, NB - 1);
                default: pat = NB'($urandom);
            endcase
            len = $urandom_range(1, 30);
            for (int c = 0; c < len; c++) begin
                @(negedge clk);
                btn_raw = ($urandom_range(0, 9) == 0) ? (pat ^ NB'($urandom)) : pat;
                rst = ($urandom_range(0, 299) == 0);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        btn_raw = '0;
        repeat (20) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
